// File: rtl/ddr_pkg.sv
// Shared types and constants for the song sequencer slice.
// Beat timing floor and lead-in depth live here so divider and FSM agree.
package ddr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_IN,
    S_PLAY,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam int MIN_PERIOD         = 4;
  localparam int LEAD_BEATS_DEFAULT = 8;

  function automatic logic is_active(input seq_state_t s);
    return (s == S_LEAD_IN) || (s == S_PLAY) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control, pattern-ROM and step-output bundle between a host and song_sequencer.
interface song_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int PER_W  = 20
);
  logic              start;
  logic              abort;
  logic              pause;
  logic [PER_W-1:0]  bpmPeriod;
  logic [ADDR_W-1:0] songLen;
  logic [ADDR_W-1:0] romAddr;
  logic [3:0]        romData;
  logic              stepEn;
  logic [3:0]        step;
  logic              playing;
  logic              done;
  logic [ADDR_W-1:0] beatIdx;

  modport master (
    output start, abort, pause, bpmPeriod, songLen, romData,
    input  romAddr, stepEn, step, playing, done, beatIdx
  );

  modport slave (
    input  start, abort, pause, bpmPeriod, songLen, romData,
    output romAddr, stepEn, step, playing, done, beatIdx
  );

endinterface

// File: rtl/beat_divider.sv
// Beat pacer: counts 0..P-1 and emits a one-cycle tick on P-1; P re-latched only at beat boundaries.
// tick is combinational from the count; run low (pause/idle) freezes the count and suppresses tick.
module beat_divider
  import ddr_pkg::*;
#(
  parameter int PER_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PERIOD);

  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] per_clamped;
  logic             at_end;

  // Short periods would let a beat outrun the two-cycle ROM prefetch.
  assign per_clamped = (period < MIN_P) ? MIN_P : period;
  assign at_end      = (cnt == per_q - PER_W'(1));
  assign tick        = run && at_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      per_q <= MIN_P;
    end else if (load || tick) begin
      cnt   <= '0;
      per_q <= per_clamped;
    end else if (run) begin
      cnt   <= cnt + PER_W'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: lead-in, ROM-driven body and drain beats, one stepEn pulse per beat.
// stepEn/step are combinational on the beat cycle; pause freezes everything, abort returns to IDLE.
module song_sequencer
  import ddr_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int PER_W      = 20,
  parameter int LEAD_BEATS = LEAD_BEATS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  song_sequencer_if.slave      bus
);

  localparam int LW = $clog2(LEAD_BEATS + 1);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              tick;
  logic              load;
  logic              run;
  logic              active;
  logic              lead_last;
  logic              body_last;
  logic [LW-1:0]     lead_cnt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] rom_addr;
  logic [ADDR_W-1:0] beat_idx;
  logic [3:0]        data_q;

  assign active    = is_active(state);
  assign load      = bus.start && !bus.abort && ((state == S_IDLE) || (state == S_DONE));
  assign run       = active && !bus.pause && !bus.abort;
  assign lead_last = (lead_cnt == LW'(LEAD_BEATS - 1));
  assign body_last = ((beat_idx + ADDR_W'(1)) == len_q);

  beat_divider #(.PER_W(PER_W)) u_div (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .run    (run),
    .period (bus.bpmPeriod),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) state_nxt = S_LEAD_IN;
        S_LEAD_IN:      if (tick && lead_last) state_nxt = (len_q == '0) ? S_DRAIN : S_PLAY;
        S_PLAY:         if (tick && body_last) state_nxt = S_DRAIN;
        S_DRAIN:        if (tick && lead_last) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stepEn  = tick;
    bus.step    = (tick && (state == S_PLAY)) ? data_q : 4'd0;
    bus.playing = active;
    bus.done    = (state == S_DONE);
    bus.romAddr = rom_addr;
    bus.beatIdx = beat_idx;
  end

  // Address moves right after a PLAY beat; data_q holds its pattern two cycles later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lead_cnt <= '0;
      len_q    <= '0;
      rom_addr <= '0;
      beat_idx <= '0;
      data_q   <= '0;
    end else begin
      data_q <= bus.romData;
      if (load) begin
        lead_cnt <= '0;
        beat_idx <= '0;
        rom_addr <= '0;
        len_q    <= bus.songLen;
      end else if (tick) begin
        case (state)
          S_LEAD_IN, S_DRAIN: lead_cnt <= lead_last ? '0 : lead_cnt + LW'(1);
          S_PLAY: begin
            beat_idx <= beat_idx + ADDR_W'(1);
            rom_addr <= rom_addr + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Sequences one song through the step display and scoring path: paces beats from a programmable clock-cycle period, fetches a 4-bit step pattern per beat from a synchronous pattern ROM, and issues one `stepEn` pulse with its `step` pattern into the step shift register.
- Beat sequence: eight blank lead-in beats, the song body, then eight blank drain beats, so every arrow scrolls fully across the 8-row column before the song ends.
- Replaces the free-running `bpmClk` + level-to-pulse front end. Scoring and score display consume `stepEn`, `playing` and `done`.

## Interface
Parameters:
- `ADDR_W`, 8, pattern ROM address width.
- `PER_W`, 20, width of the beat-period count.
- `LEAD_BEATS`, 8, blank beats before and after the song body; matches column depth.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately; deassertion is synchronous to `clk`.
- `start`  in  1  single-cycle pulse; begins a song from IDLE or DONE.
- `abort`  in  1  level; returns to IDLE from any state.
- `pause`  in  1  level; freezes the beat counter and FSM in LEAD_IN, PLAY and DRAIN.
- `bpmPeriod`  in  PER_W  clk cycles per beat. Values below 4 are treated as 4.
- `songLen`  in  ADDR_W  number of body beats; 0 means the body is skipped.
- `romAddr`  out  ADDR_W  pattern ROM address.
- `romData`  in  4  pattern at `romAddr`, valid one cycle after the address changes.
- `stepEn`  out  1  one-cycle beat pulse.
- `step`  out  4  pattern qualified by `stepEn`; 0 when `stepEn` is low.
- `playing`  out  1  high in LEAD_IN, PLAY and DRAIN.
- `done`  out  1  high in DONE.
- `beatIdx`  out  ADDR_W  body beats issued so far.

## Operation
States: IDLE, LEAD_IN, PLAY, DRAIN, DONE.
- IDLE → LEAD_IN on `start`. Clears the beat counter, `beatIdx` and `romAddr`, and latches `bpmPeriod` and `songLen`.
- LEAD_IN: issues `LEAD_BEATS` beats with `step`=0.
  - After the last one, go to PLAY, or to DRAIN if `songLen`=0.
- PLAY: each beat issues `step`=the prefetched `romData` and increments `beatIdx`.
  - After beat number `songLen`, go to DRAIN.
- DRAIN: issues `LEAD_BEATS` beats with `step`=0, then goes to DONE.
- DONE: holds `done`. `start` → LEAD_IN, with the same clears and latches as from IDLE.
- `abort` from any state → IDLE on the next edge. No further `stepEn` is issued.
- `start` in LEAD_IN, PLAY or DRAIN is ignored. `start` and `abort` together: `abort` wins.

Beat counter:
- Counts 0 to P-1, where P is the latched period.
- On the cycle the count equals P-1: assert `stepEn`, wrap the count to 0, and re-latch `bpmPeriod`. A new period therefore takes effect only at a beat boundary.

ROM prefetch:
- `romAddr` advances by 1 on the cycle after each PLAY beat.
- `romData` is registered internally two cycles after the address changes. The minimum period of 4 guarantees this completes before the next beat.
- Address wraps modulo 2^ADDR_W.

Reset values: FSM=IDLE. All outputs 0, including `romAddr`, `beatIdx` and `step`.

## Timing
- First `stepEn` occurs P cycles after the `start` pulse: `start` is sampled at edge 0, the pulse is at edge P.
- Beat spacing is exactly P cycles while not paused.
- `pause` asserted: the counter holds, no `stepEn` is issued, and outputs hold. On release, counting resumes from the held value.
- `pause` on a cycle where the count is P-1 suppresses that beat; the beat is issued on the first unpaused cycle.
- Total `stepEn` pulses per song: 2·LEAD_BEATS + `songLen`.
- `done` rises on the cycle after the last DRAIN `stepEn`.
- `reset` low mid-song: outputs drop to 0 asynchronously, with no partial pulse.

## Structure
- `ddr_pkg`: state enum `seq_state_t`, `MIN_PERIOD`=4, `LEAD_BEATS` default.
- Sub-module `beat_divider`: period latch, counter, pause and clamp logic; outputs a one-cycle `tick`.
- FSM, prefetch register and address/beat counters live in `song_sequencer`.

## Test plan
- Reset, then `start`, with `bpmPeriod`=10, `songLen`=3, ROM={1,2,4} → 19 pulses 10 cycles apart: 8×0, then 1,2,4, then 8×0. `done` goes high after the 19th pulse.
- `bpmPeriod`=2 → pulses are 4 cycles apart and `step` data is still correct.
- `bpmPeriod` changes from 10 to 20 after pulse 9 → pulse 10 at +10 cycles, pulse 11 at +20.
- `pause` held for 50 cycles during PLAY → exactly 50 extra cycles between pulses, with no lost or duplicated pattern.
- `abort` together with `start` during PLAY → IDLE next cycle and no further `stepEn`. A later `start` restarts at `romAddr`=0.
- `reset` low for 1 cycle mid-DRAIN → all outputs 0 at once and the FSM in IDLE. `songLen`=0 → 16 blank pulses, then DONE.
